vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 VGA raster timing from the pixel clock: scan position
//  (DrawX/DrawY), display-enable (blank), hsync/vsync and frame/line markers.
//  Sits directly upstream of the sprite/background renderers. Those renderers
//  read a ROM on the negedge and register colour on the posedge. The syncs are
//  therefore delayed to line up with the colour they output.
// PARAMETERS
//  H_VISIBLE   640  visible pixels per line
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   hsync pulse width (pixels)
//  H_BP        48   horizontal back porch; H_TOTAL = sum = 800
//  V_VISIBLE   480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync pulse width (lines)
//  V_BP        33   vertical back porch; V_TOTAL = sum = 525
//  SYNC_DELAY  1    extra cycles of hs/vs delay vs DrawX/blank, legal 0..3
// PORTS
//  vga_clk      in   1   pixel clock (25 MHz nominal); all logic on posedge
//  reset        in   1   asynchronous, active-high reset
//  DrawX        out  10  current column, 0..H_TOTAL-1 (not clamped in porch)
//  DrawY        out  10  current row, 0..V_TOTAL-1
//  blank        out  1   display enable: 1 = visible pixel, 0 = blanking
//  hs           out  1   horizontal sync, active low
//  vs           out  1   vertical sync, active low
//  line_start   out  1   1-cycle pulse while DrawX==0
//  frame_start  out  1   1-cycle pulse while DrawX==0 && DrawY==0
//  frame_count  out  16  completed-frame counter, wraps 0xFFFF->0
// BEHAVIOUR
//  - Counters: internal hc/vc. hc increments each cycle and wraps
//    H_TOTAL-1 -> 0. vc increments only when hc wraps, and wraps V_TOTAL-1 -> 0.
//  - Output stage: DrawX, DrawY, blank, line_start and frame_start are all
//    registered from a decode of hc/vc. They are mutually coincident and lag
//    the counters by 1 cycle. No output is a combinational decode.
//  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE), evaluated in the same
//    stage as DrawX/DrawY.
//  - Raw syncs, each active low and decoded in the same stage as DrawX:
//    hs_raw = 0 for H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
//    vs_raw = 0 for V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
//  - hs/vs are hs_raw/vs_raw passed through a SYNC_DELAY-deep shift register.
//    SYNC_DELAY=0 makes them coincident with DrawX.
//  - frame_count increments on the same edge on which frame_start rises,
//    except on the first frame after reset. That frame shows frame_count=0.
//  - Reset (async assert, sync release):
//    * hc=vc=0.
//    * DrawX=0, DrawY=0, blank=0, line_start=0, frame_start=0, frame_count=0.
//    * hs=vs=1, and every sync delay stage is filled with 1.
//  - First posedge after reset release:
//    * DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1.
//    * hc advances to 1.
//    * Frame 0 is never skipped or shortened.
//  - Reset mid-frame aborts immediately; timing restarts cleanly from (0,0).
//  - Widths: 10-bit counters hold up to 1023 >= H_TOTAL-1. Overflow is
//    impossible with legal parameters; wrap compares use ==, not overflow.
//  - Simultaneous line and frame wrap: vc wraps on the same edge hc wraps.
//    frame_start and line_start both pulse at the new (0,0).
// TESTING
//  1 Hold reset 5 cycles -> DrawX=0, DrawY=0, blank=0, hs=vs=1,
//    frame_start=0, frame_count=0.
//  2 Release reset -> next edge DrawX=0, DrawY=0, blank=1, frame_start=1.
//    frame_start pulse lasts exactly 1 cycle.
//  3 Line scan (SYNC_DELAY=1):
//    * blank high for exactly 640 cycles of 800.
//    * hs low for 96 cycles, first low 1 cycle after DrawX=656.
//    * DrawX 799 -> 0 with DrawY+1.
//  4 Frame scan:
//    * 525 lines; vs low exactly 1600 cycles (lines 490-491, delayed 1).
//    * DrawY 524 -> 0 with frame_start=1 and frame_count 0 -> 1.
//    * 307200 blank-high cycles per frame.
//  5 Assert reset at DrawX=300, DrawY=200 for 1 cycle.
//    -> Outputs go to reset values asynchronously, before the next edge.
//    -> After release, the sequence restarts exactly as in scenario 2.
//  6 SYNC_DELAY=0 and =3 builds -> hs falls coincident with DrawX=656,
//    or 3 cycles after it; pulse width unchanged at 96.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for 640x480@60 VGA, clocked by the pixel clock.
//   Produces the scan position, display enable, active-low syncs and
//   line/frame markers consumed by the sprite/background renderers.
//
//   The renderers read ROM on the negedge and register colour on the posedge,
//   so their colour lags DrawX by one more cycle than a plain decode would.
//   hs/vs are therefore pushed through a SYNC_DELAY-deep shift register so
//   they line up with the colour actually leaving the renderers.
//
// Ports
//   vga_clk      in   1   pixel clock, all logic on posedge
//   reset        in   1   asynchronous active-high reset
//   DrawX        out  10  current column 0..H_TOTAL-1 (not clamped in porch)
//   DrawY        out  10  current row    0..V_TOTAL-1
//   blank        out  1   1 = visible pixel, 0 = blanking
//   hs           out  1   horizontal sync, active low, SYNC_DELAY late
//   vs           out  1   vertical sync, active low, SYNC_DELAY late
//   line_start   out  1   pulse while DrawX == 0
//   frame_start  out  1   pulse while DrawX == 0 && DrawY == 0
//   frame_count  out  16  completed frames, wraps 0xFFFF -> 0
//
// SYNC_DELAY is meaningful in the range 0..3.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Decode constants, all sized to the 10-bit counters.
  localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] C_HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] C_VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       w_h_wrap;
  logic       w_v_wrap;

  // Equality compares: with legal parameters the counters never reach 1023,
  // so wrap is purely the terminal-count match.
  assign w_h_wrap = (r_hc == C_H_LAST);
  assign w_v_wrap = (r_vc == C_V_LAST);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_wrap) begin
      r_hc <= '0;
      r_vc <= w_v_wrap ? 10'd0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Position decode (feeds the single output register stage)
  // -------------------------------------------------------------------------
  logic w_vis;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_line;
  logic w_frame;

  assign w_vis    = (r_hc < C_H_VIS) && (r_vc < C_V_VIS);
  assign w_hs_raw = !((r_hc >= C_HS_BEG) && (r_hc < C_HS_END));
  assign w_vs_raw = !((r_vc >= C_VS_BEG) && (r_vc < C_VS_END));
  assign w_line   = (r_hc == 10'd0);
  assign w_frame  = (r_hc == 10'd0) && (r_vc == 10'd0);

  // -------------------------------------------------------------------------
  // Output stage: everything here is coincident and one cycle behind hc/vc.
  // -------------------------------------------------------------------------
  logic [9:0] r_drawx;
  logic [9:0] r_drawy;
  logic       r_blank;
  logic       r_line;
  logic       r_frame;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_drawx <= '0;
      r_drawy <= '0;
      r_blank <= 1'b0;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_drawx <= r_hc;
      r_drawy <= r_vc;
      r_blank <= w_vis;
      r_line  <= w_line;
      r_frame <= w_frame;
    end
  end

  // -------------------------------------------------------------------------
  // Sync delay line. Stage 0 is coincident with DrawX; the outputs tap stage
  // SYNC_DELAY. All stages reset to the inactive (high) level so no spurious
  // sync pulse leaks out after reset release.
  // -------------------------------------------------------------------------
  logic [SYNC_DELAY:0] r_hs_pipe;
  logic [SYNC_DELAY:0] r_vs_pipe;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hs_pipe <= '1;
      r_vs_pipe <= '1;
    end else begin
      r_hs_pipe[0] <= w_hs_raw;
      r_vs_pipe[0] <= w_vs_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frame counter. The first (0,0) after reset opens frame 0 rather than
  // completing one, so r_started suppresses that single increment.
  // -------------------------------------------------------------------------
  logic [15:0] r_fcnt;
  logic        r_started;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_fcnt    <= '0;
      r_started <= 1'b0;
    end else if (w_frame) begin
      r_started <= 1'b1;
      if (r_started) r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign DrawX       = r_drawx;
  assign DrawY       = r_drawy;
  assign blank       = r_blank;
  assign line_start  = r_line;
  assign frame_start = r_frame;
  assign hs          = r_hs_pipe[SYNC_DELAY];
  assign vs          = r_vs_pipe[SYNC_DELAY];
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Four instances share clock and reset:
//   full : 640x480 timing, SYNC_DELAY=1 (reset, line scan, mid-frame reset)
//   small: shrunken raster, SYNC_DELAY=1 (whole-frame behaviour in few cycles)
//   d0/d3: 640x480 timing, SYNC_DELAY=0 and 3
// Expected values come from a position model: the number of edges since
// reset release gives the scan index, from which x/y/syncs/frame count follow
// by plain division and modulo.
module tb_vga_timing_gen;

  localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;   // 25
  localparam int SVT = SVV + SVF + SVS + SVB;   // 15

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0]  x_f, y_f, x_s, y_s, x_z, y_z, x_t, y_t;
  logic        b_f, hs_f, vs_f, ls_f, fs_f;
  logic        b_s, hs_s, vs_s, ls_s, fs_s;
  logic        b_z, hs_z, vs_z, ls_z, fs_z;
  logic        b_t, hs_t, vs_t, ls_t, fs_t;
  logic [15:0] fc_f, fc_s, fc_z, fc_t;

  logic [40:0] ob_f, ob_s, ob_z, ob_t;
  assign ob_f = {x_f, y_f, b_f, hs_f, vs_f, ls_f, fs_f, fc_f};
  assign ob_s = {x_s, y_s, b_s, hs_s, vs_s, ls_s, fs_s, fc_s};
  assign ob_z = {x_z, y_z, b_z, hs_z, vs_z, ls_z, fs_z, fc_z};
  assign ob_t = {x_t, y_t, b_t, hs_t, vs_t, ls_t, fs_t, fc_t};

  vga_timing_gen u_full (
    .vga_clk(clk), .reset(rst), .DrawX(x_f), .DrawY(y_f), .blank(b_f),
    .hs(hs_f), .vs(vs_f), .line_start(ls_f), .frame_start(fs_f), .frame_count(fc_f));

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_DELAY(1)
  ) u_small (
    .vga_clk(clk), .reset(rst), .DrawX(x_s), .DrawY(y_s), .blank(b_s),
    .hs(hs_s), .vs(vs_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s));

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset(rst), .DrawX(x_z), .DrawY(y_z), .blank(b_z),
    .hs(hs_z), .vs(vs_z), .line_start(ls_z), .frame_start(fs_z), .frame_count(fc_z));

  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .vga_clk(clk), .reset(rst), .DrawX(x_t), .DrawY(y_t), .blank(b_t),
    .hs(hs_t), .vs(vs_t), .line_start(ls_t), .frame_start(fs_t), .frame_count(fc_t));

  int    n_checks = 0;
  int    n_pass   = 0;
  longint k = 0;   // edges since reset release (0 while in reset)

  // Reference model: output bundle after kk edges since release.
  function automatic logic [40:0] model(int HV, int HF, int HSW, int HB,
                                        int VV, int VF, int VSW, int VB,
                                        int D, longint kk);
    longint ht, vt, p, q, x, y, qx, qy;
    logic   bl, h, v, ls, fs;
    logic [15:0] fc;
    ht = HV + HF + HSW + HB;
    vt = VV + VF + VSW + VB;
    if (kk == 0) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    p  = kk - 1;
    x  = p % ht;
    y  = (p / ht) % vt;
    bl = (x < HV) && (y < VV);
    ls = (x == 0);
    fs = (x == 0) && (y == 0);
    fc = 16'(p / (ht * vt));
    q  = p - D;
    h  = 1'b1;
    v  = 1'b1;
    if (q >= 0) begin
      qx = q % ht;
      qy = (q / ht) % vt;
      h  = !((qx >= HV + HF) && (qx < HV + HF + HSW));
      v  = !((qy >= VV + VF) && (qy < VV + VF + VSW));
    end
    return {10'(x), 10'(y), bl, h, v, ls, fs, fc};
  endfunction

  function automatic logic [40:0] mf(longint kk);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1, kk);
  endfunction
  function automatic logic [40:0] ms(longint kk);
    return model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1, kk);
  endfunction
  function automatic logic [40:0] mz(longint kk);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 0, kk);
  endfunction
  function automatic logic [40:0] mt(longint kk);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 3, kk);
  endfunction

  // Advance one edge and move to the sample point just after it.
  task automatic step;
    @(posedge clk);
    #1;
    if (rst) k = 0;
    else     k = k + 1;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    #1;
    n = $urandom_range(5, 9);
    repeat (n) begin
      step;
      n_checks++;
      if (ob_f !== mf(0)) $display("FAIL reset_full got=%h exp=%h", ob_f, mf(0));
      else n_pass++;
      n_checks++;
      if (ob_s !== ms(0)) $display("FAIL reset_small got=%h exp=%h", ob_s, ms(0));
      else n_pass++;
    end
  endtask

  task automatic test_release;
    rst = 1'b0;
    step;
    n_checks++;
    if ({x_f, y_f, b_f, ls_f, fs_f, fc_f} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'd0})
      $display("FAIL release_first got=%h exp=%h", {x_f, y_f, b_f, ls_f, fs_f, fc_f},
               {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'd0});
    else n_pass++;
    n_checks++;
    if (ob_f !== mf(k)) $display("FAIL release_model k=%0d got=%h exp=%h", k, ob_f, mf(k));
    else n_pass++;
    step;
    n_checks++;
    if (fs_f !== 1'b0 || x_f !== 10'd1)
      $display("FAIL release_pulse fs=%b x=%0d exp fs=0 x=1", fs_f, x_f);
    else n_pass++;
  endtask

  // Whole frames on the small raster, starting right after release.
  task automatic test_frame;
    logic [15:0] pfc;
    logic [9:0]  px, py;
    int nb = 0, nv = 0, nf = 0, nl = 0, seen = 0;
    pfc = fc_s; px = x_s; py = y_s;
    while (k < 2 * SHT * SVT + 1) begin
      step;
      n_checks++;
      if (ob_s !== ms(k)) $display("FAIL frame_model k=%0d got=%h exp=%h", k, ob_s, ms(k));
      else n_pass++;
      if (k >= SHT * SVT + 2) begin
        nb += int'(b_s); nv += int'(!vs_s); nf += int'(fs_s); nl += int'(ls_s);
      end
      if (fs_s) begin
        seen++;
        n_checks++;
        if (px !== 10'(SHT - 1) || py !== 10'(SVT - 1) || y_s !== 10'd0 || fc_s !== pfc + 16'd1)
          $display("FAIL frame_wrap px=%0d py=%0d y=%0d fc=%0d prev_fc=%0d", px, py, y_s, fc_s, pfc);
        else n_pass++;
      end
      pfc = fc_s; px = x_s; py = y_s;
    end
    n_checks++;
    if (nb !== SHV * SVV) $display("FAIL frame_blank got=%0d exp=%0d", nb, SHV * SVV);
    else n_pass++;
    n_checks++;
    if (nv !== SVS * SHT) $display("FAIL frame_vs_low got=%0d exp=%0d", nv, SVS * SHT);
    else n_pass++;
    n_checks++;
    if (nf !== 1 || nl !== SVT || seen !== 2)
      $display("FAIL frame_markers fs=%0d ls=%0d wraps=%0d exp 1 %0d 2", nf, nl, seen, SVT);
    else n_pass++;
  endtask

  // One full 800-cycle line on the 640x480 instance.
  task automatic test_line;
    int c = 0, nb = 0, nh = 0, c656 = -1, cfall = -1;
    bit started = 0;
    logic [9:0] px, py;
    repeat ($urandom_range(0, 40)) step;
    px = x_f; py = y_f;
    for (int i = 0; i < 1700 && c < 800; i++) begin
      step;
      n_checks++;
      if (ob_f !== mf(k)) $display("FAIL line_model k=%0d got=%h exp=%h", k, ob_f, mf(k));
      else n_pass++;
      if (!started && ls_f) started = 1;
      if (started) begin
        nb += int'(b_f);
        if (!hs_f) begin nh++; if (cfall < 0) cfall = c; end
        if (x_f == 10'd656) c656 = c;
        c++;
      end
      if (px == 10'd799) begin
        n_checks++;
        if (x_f !== 10'd0 || y_f !== py + 10'd1)
          $display("FAIL line_wrap x=%0d y=%0d prev_y=%0d", x_f, y_f, py);
        else n_pass++;
      end
      px = x_f; py = y_f;
    end
    n_checks++;
    if (c !== 800) $display("FAIL line_timeout cycles=%0d exp=800", c);
    else n_pass++;
    n_checks++;
    if (nb !== 640) $display("FAIL line_blank got=%0d exp=640", nb);
    else n_pass++;
    n_checks++;
    if (nh !== 96) $display("FAIL line_hs_width got=%0d exp=96", nh);
    else n_pass++;
    n_checks++;
    if (cfall - c656 !== 1) $display("FAIL line_hs_offset got=%0d exp=1", cfall - c656);
    else n_pass++;
  endtask

  task automatic test_midreset;
    int tx, ty;
    bit hit = 0;
    ty = $urandom_range(2, 3);
    tx = $urandom_range(100, 700);
    for (int i = 0; i < 3000 && !hit; i++) begin
      step;
      n_checks++;
      if (ob_f !== mf(k)) $display("FAIL mid_model k=%0d got=%h exp=%h", k, ob_f, mf(k));
      else n_pass++;
      if (x_f == 10'(tx) && y_f == 10'(ty)) hit = 1;
    end
    n_checks++;
    if (!hit) $display("FAIL mid_wait x=%0d y=%0d target %0d %0d", x_f, y_f, tx, ty);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ob_f !== mf(0) || ob_s !== ms(0))
      $display("FAIL mid_async full=%h small=%h exp=%h", ob_f, ob_s, mf(0));
    else n_pass++;
    step;
    n_checks++;
    if (ob_f !== mf(0) || ob_t !== mt(0))
      $display("FAIL mid_hold full=%h d3=%h exp=%h", ob_f, ob_t, mf(0));
    else n_pass++;
    test_release;
  endtask

  task automatic test_sync_delay;
    int c = 0, c656 = -1, nz = 0, nt = 0, fz = -1, ft = -1;
    bit started = 0;
    for (int i = 0; i < 2000 && c < 800; i++) begin
      step;
      n_checks++;
      if (ob_z !== mz(k)) $display("FAIL d0_model k=%0d got=%h exp=%h", k, ob_z, mz(k));
      else n_pass++;
      n_checks++;
      if (ob_t !== mt(k)) $display("FAIL d3_model k=%0d got=%h exp=%h", k, ob_t, mt(k));
      else n_pass++;
      if (!started && ls_z && k > 1) started = 1;
      if (started) begin
        if (!hs_z) begin nz++; if (fz < 0) fz = c; end
        if (!hs_t) begin nt++; if (ft < 0) ft = c; end
        if (x_z == 10'd656) c656 = c;
        c++;
      end
    end
    n_checks++;
    if (c !== 800 || nz !== 96 || nt !== 96)
      $display("FAIL sync_width cycles=%0d d0=%0d d3=%0d exp 800 96 96", c, nz, nt);
    else n_pass++;
    n_checks++;
    if (fz - c656 !== 0) $display("FAIL d0_offset got=%0d exp=0", fz - c656);
    else n_pass++;
    n_checks++;
    if (ft - c656 !== 3) $display("FAIL d3_offset got=%0d exp=3", ft - c656);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    #1;
    test_reset;
    test_release;
    test_frame;
    test_line;
    test_midreset;
    test_sync_delay;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
